// File: rtl/dup_op_feeder_if.sv
// Handshake and operand bundle for the command-buffering issue stage.
// The slave modport is the feeder's view; master is the surrounding environment.
interface dup_op_feeder_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_mode;
  logic [W-1:0]  in_val1;
  logic [W-1:0]  in_val2;

  logic [2:0]    alu_mode;
  logic [W-1:0]  alu_val1;
  logic [W-1:0]  alu_val2;
  logic [W-1:0]  alu_res;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic [2:0]    out_mode;

  logic [LW-1:0] level;

  modport slave (
    input  in_valid, in_mode, in_val1, in_val2, alu_res, out_ready,
    output in_ready, alu_mode, alu_val1, alu_val2, out_valid, out_res, out_mode, level
  );

  modport master (
    output in_valid, in_mode, in_val1, in_val2, alu_res, out_ready,
    input  in_ready, alu_mode, alu_val1, alu_val2, out_valid, out_res, out_mode, level
  );
endinterface

// File: rtl/dup_op_feeder.sv
// Issue stage: queues (mode, val1, val2) commands, presents the FIFO head to a
// combinational arithmetic unit and returns registered results in order.
module dup_op_feeder #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dup_op_feeder_if.slave        bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef struct packed {
    logic [2:0]   mode;
    logic [W-1:0] val1;
    logic [W-1:0] val2;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          out_valid_q;
  logic [W-1:0]  out_res_q;
  logic [2:0]    out_mode_q;

  logic          push;
  logic          load;
  logic          not_empty;
  cmd_t          head;

  assign not_empty = (count != '0);
  assign bus.in_ready = (count != FULL) && !rst;
  assign push = bus.in_valid && bus.in_ready;
  // The output register frees up in the same cycle it is consumed.
  assign load = not_empty && (!out_valid_q || bus.out_ready);

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    head = '0;
    if (not_empty) head = mem[rd_ptr];
  end

  assign bus.alu_mode  = head.mode;
  assign bus.alu_val1  = head.val1;
  assign bus.alu_val2  = head.val2;

  // NOTE: the command storage has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_t'{mode: bus.in_mode, val1: bus.in_val1, val2: bus.in_val2};
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_mode_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) begin
        rd_ptr      <= rd_ptr + AW'(1);
        out_res_q   <= bus.alu_res;
        out_mode_q  <= head.mode;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case ({push, load})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.level     = count;
endmodule

// File: tb/tb_dup_op_feeder.sv
// Directed bench for dup_op_feeder with a small reference arithmetic unit
// attached to the operand ports.
module tb_dup_op_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dup_op_feeder_if #(.W(8), .DEPTH(4)) bus ();

  dup_op_feeder #(.W(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference unit: 000 pass, 001 add, 010 xor, 011 sub, 100 max, 101 min, 110 or, 111 and.
  function automatic logic [7:0] ref_alu(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    case (m)
      3'b000:  return a;
      3'b001:  return a + b;
      3'b010:  return a ^ b;
      3'b011:  return a - b;
      3'b100:  return (a > b) ? a : b;
      3'b101:  return (a < b) ? a : b;
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  assign bus.alu_res = ref_alu(bus.alu_mode, bus.alu_val1, bus.alu_val2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_val1  = a;
    bus.in_val2  = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b001, 8'd1, 8'd1);
    tick();
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_res !== 8'd0) begin errors++; $display("FAIL reset_out_res got %0h want 0", bus.out_res); end
    checks++; if (bus.out_mode !== 3'd0) begin errors++; $display("FAIL reset_out_mode got %0d want 0", bus.out_mode); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.level); end
    rst = 1'b0;
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.alu_mode !== 3'd0 || bus.alu_val1 !== 8'd0 || bus.alu_val2 !== 8'd0) begin
      errors++; $display("FAIL empty_head got %0d/%0h/%0h want 0/0/0", bus.alu_mode, bus.alu_val1, bus.alu_val2);
    end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b001, 8'd5, 8'd3);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b want 1", bus.in_ready); end
    tick();
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    checks++; if (bus.level !== 3'd1) begin errors++; $display("FAIL single_level got %0d want 1", bus.level); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.alu_mode !== 3'b001 || bus.alu_val1 !== 8'd5 || bus.alu_val2 !== 8'd3) begin
      errors++; $display("FAIL single_head got %0d/%0h/%0h want 1/5/3", bus.alu_mode, bus.alu_val1, bus.alu_val2);
    end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_res !== 8'd8) begin errors++; $display("FAIL single_res got %0d want 8", bus.out_res); end
    checks++; if (bus.out_mode !== 3'b001) begin errors++; $display("FAIL single_mode got %0d want 1", bus.out_mode); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL single_level_after got %0d want 0", bus.level); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", bus.out_valid); end
    checks++; if (bus.out_res !== 8'd8) begin errors++; $display("FAIL single_hold got %0d want 8", bus.out_res); end
  endtask

  // Six add commands (i*10 + i) against a stalled consumer, then release.
  task automatic test_backpressure();
    logic [7:0] want [5] = '{8'd22, 8'd33, 8'd44, 8'd55, 8'd66};
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 3'b001, 8'(i * 10), 8'(i));
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready_%0d got %b want 1", i, bus.in_ready); end
      tick();
    end
    drive(1'b1, 3'b001, 8'd60, 8'd6);
    checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL fill_level got %0d want 4", bus.level); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_res !== 8'd11) begin
      errors++; $display("FAIL fill_out got %b/%0d want 1/11", bus.out_valid, bus.out_res);
    end
    tick();
    checks++; if (bus.out_res !== 8'd11 || bus.level !== 3'd4) begin
      errors++; $display("FAIL stall_hold got %0d/%0d want 11/4", bus.out_res, bus.level);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL full_sim_level got %0d want 3", bus.level); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_sim_ready got %b want 1", bus.in_ready); end
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        checks++; if (bus.out_res !== want[0]) begin errors++; $display("FAIL drain_0 got %0d want %0d", bus.out_res, want[0]); end
      end else begin
        tick();
        if (i == 1) begin
          drive(1'b0, 3'b000, 8'd0, 8'd0);
          checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL full_sim_push got level %0d want 3", bus.level); end
        end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_res !== want[i]) begin
          errors++; $display("FAIL drain_%0d got %b/%0d want 1/%0d", i, bus.out_valid, bus.out_res, want[i]);
        end
      end
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin
      errors++; $display("FAIL drain_end got %b/%0d want 0/0", bus.out_valid, bus.level);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] m    [3] = '{3'b011, 3'b100, 3'b110};
    logic [7:0] a    [3] = '{8'd10, 8'd7, 8'hF0};
    logic [7:0] b    [3] = '{8'd0, 8'd9, 8'h0F};
    logic [7:0] want [3] = '{8'd10, 8'd9, 8'hFF};
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) drive(1'b1, m[i], a[i], b[i]);
      else       drive(1'b0, 3'b000, 8'd0, 8'd0);
      #1;
      if (i < 3) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b want 1", i, bus.in_ready); end
      end
      tick();
      if (i > 0) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_res !== want[i-1] || bus.out_mode !== m[i-1]) begin
          errors++; $display("FAIL b2b_res_%0d got %b/%0h/%0d want 1/%0h/%0d", i - 1, bus.out_valid, bus.out_res, bus.out_mode, want[i-1], m[i-1]);
        end
      end
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b001, 8'(i + 1), 8'd100);
      tick();
    end
    checks++; if (bus.level !== 3'd3 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_setup got %0d/%b want 3/1", bus.level, bus.out_valid);
    end
    rst = 1'b1;
    drive(1'b1, 3'b101, 8'd9, 8'd9);
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.level !== 3'd0 || bus.out_res !== 8'd0 || bus.out_mode !== 3'd0) begin
      errors++; $display("FAIL mid_reset got %b/%0d/%0h/%0d want 0/0/0/0", bus.out_valid, bus.level, bus.out_res, bus.out_mode);
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b111, 8'h3C, 8'h0F);
    tick();
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    checks++; if (bus.level !== 3'd1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_accept got %0d/%b want 1/0", bus.level, bus.out_valid);
    end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_res !== 8'h0C || bus.out_mode !== 3'b111) begin
      errors++; $display("FAIL mid_fresh got %b/%0h/%0d want 1/c/7", bus.out_valid, bus.out_res, bus.out_mode);
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin
      errors++; $display("FAIL mid_end got %b/%0d want 0/0", bus.out_valid, bus.level);
    end
  endtask

  initial begin
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dup_op_feeder.md
# dup_op_feeder

Command-buffering issue stage that sits directly upstream of the mode-select arithmetic unit. It accepts (mode, val1, val2) commands over a valid/ready handshake and queues them in a small FIFO. It presents the FIFO head to the combinational unit's operand ports, captures the unit's result into an output register, and returns the result in order over a second valid/ready handshake. It decouples the unit from bursty producers and from a stalling consumer.

## Interface
- W, 8: operand and result width; must match the arithmetic unit.
- DEPTH, 4: command FIFO entries; power of two, ≥ 2.

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command offered
- in_ready  out  1  command accepted when in_valid && in_ready at an edge
- in_mode  in  3  operation select
- in_val1  in  W  operand 1
- in_val2  in  W  operand 2
- alu_mode  out  3  to arithmetic unit `mode`
- alu_val1  out  W  to arithmetic unit `val1`
- alu_val2  out  W  to arithmetic unit `val2`
- alu_res  in  W  from arithmetic unit `res` (combinational, same cycle)
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer takes result when out_valid && out_ready at an edge
- out_res  out  W  registered result
- out_mode  out  3  mode that produced out_res
- level  out  $clog2(DEPTH)+1  FIFO occupancy (excludes the output register)

## Operation
- FIFO: circular buffer with wr_ptr, rd_ptr and a registered count. Pointers wrap modulo DEPTH.
- Push: occurs when in_valid && in_ready. in_ready = (count != DEPTH) && !rst. A pop in the same cycle does not free a slot for a push when full, so no push while full.
- Head drive: when count > 0, alu_mode/alu_val1/alu_val2 = FIFO[rd_ptr] combinationally. When empty, they are all 0.
- Load condition: load = (count > 0) && (!out_valid || out_ready).
- On load at an edge:
  - out_res ← alu_res; out_mode ← head mode; out_valid ← 1.
  - rd_ptr advances; count decrements unless a push occurs in the same cycle.
- Drain: if out_valid && out_ready && count == 0, then out_valid ← 0. out_res and out_mode hold their last values.
- Simultaneous push and load: count is unchanged and both pointers advance.
- Ordering: results leave strictly in command-acceptance order. No command is dropped or duplicated.
- Width: alu_res is taken as-is, with no extension or truncation in this block. Modes 3'b101..3'b111 are forwarded unchanged.
- Reset (rst high at an edge): pointers, count and level ← 0; out_valid ← 0; out_res ← 0; out_mode ← 0. The FIFO contents need not be cleared. Reset mid-operation discards all queued and held commands. A handshake in the reset cycle is ignored.

## Timing
- Latency: a command accepted at edge N into an empty FIFO with a free output register appears with out_valid = 1 after edge N+1.
- Throughput: one command per cycle sustained while out_ready = 1.
- Buffering: total capacity is DEPTH + 1 commands (FIFO plus output register). With out_ready held at 0, in_ready falls after the (DEPTH+1)th acceptance.
- in_ready and level depend only on registered state. in_ready does not depend on in_valid or out_ready combinationally.
- out_valid, out_res and out_mode are registered and stable while out_valid && !out_ready.
- In the first cycle after reset deasserts, in_ready = 1 and out_valid = 0.

## Test plan
- Reset: hold rst for 2 cycles with in_valid = 1 → no accepts, out_valid = 0, out_res = 0, level = 0. After release, in_ready = 1.
- Single command: mode = 3'b001, val1 = 8'd5, val2 = 8'd3, with a reference unit attached and out_ready = 1 → out_valid one cycle after acceptance, out_res = 8'd8, out_mode = 3'b001, then out_valid = 0.
- Backpressure fill: out_ready = 0, offer 6 commands → 5 accepted, level = 4, in_ready = 0. Set out_ready = 1 → the 5 results drain in order, one per cycle. The 6th command is then accepted.
- Mixed modes back-to-back with out_ready = 1:
  - mode 3'b011, val1 = 10, val2 = 0 → out_res = 10.
  - mode 3'b100, val1 = 7, val2 = 9 → out_res = 9.
  - mode 3'b110, val1 = 8'hF0, val2 = 8'h0F → out_res = 8'hFF.
  - Expect one result per cycle.
- Full with simultaneous events: level = 4, out_valid = 1, out_ready = 1, in_valid = 1 → pop occurs, push rejected (in_ready = 0), level becomes 3. The next cycle accepts the push.
- Reset mid-stream: assert rst with level = 3 and out_valid = 1 → after the edge, out_valid = 0, level = 0. The next command returns its own result with no stale data.
